// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// Shared constants and types for the UART FIFO controllers (RX and TX side).
// Holds the flow-control state encodings, the default geometry/watermarks
// and the per-cycle FIFO operation bundle.
package uart_rx_fifo_ctrl_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEF_AW    = 3;
  localparam int unsigned DEF_HI_WM = 6;
  localparam int unsigned DEF_LO_WM = 2;

  // Flow-control state doubles as the RTS level: ON drives 0, OFF drives 1.
  typedef enum logic {
    FLOW_ON  = 1'b0,
    FLOW_OFF = 1'b1
  } flow_state_e;

  // Qualified actions taken by the FIFO in one cycle.
  typedef struct packed {
    logic push;
    logic pop;
    logic ovf_set;
  } fifo_op_t;

endpackage

// File: rtl/uart_rx_fifo_ctrl_ram.sv
// rxfifo_ram: 2**AW x 8 register-array storage for the RX FIFO.
// Synchronous write, asynchronous read so the head byte is visible
// as soon as the read pointer moves.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address (write pointer)
//   i_wdata  write byte
//   i_raddr  read address (read pointer)
//   o_rdata  byte at i_raddr
module rxfifo_ram
  import uart_rx_fifo_ctrl_pkg::*;
#(
  parameter int unsigned AW = DEF_AW
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [7:0]        o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage carries no reset; emptiness is tracked by the controller's count.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: receive-side FIFO controller between uart_rx and the CPU bus.
// Captures received bytes into a 2**AW deep FIFO, presents the head byte
// show-ahead, tracks a sticky overrun flag and drives RTS with hysteresis.
//   clk      system clock
//   rstn     asynchronous active-low reset
//   rx_rcv   one-cycle pulse: rx_data valid
//   rx_data  received byte
//   rd       CPU pop strobe
//   flush    synchronous FIFO clear (priority over push/pop)
//   ovf_clr  clear sticky overrun flag
//   rd_data  head byte, 0x00 when empty
//   ready    FIFO not empty
//   count    occupancy 0..2**AW
//   ovf      sticky overrun
//   rts_n    0 = sender may transmit, 1 = stop
module uart_rx_fifo_ctrl
  import uart_rx_fifo_ctrl_pkg::*;
#(
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned HI_WM = DEF_HI_WM,
  parameter int unsigned LO_WM = DEF_LO_WM
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_rcv,
  input  logic [7:0]    rx_data,
  input  logic          rd,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic [7:0]    rd_data,
  output logic          ready,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          rts_n
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_ovf;
  flow_state_e       r_flow;
  flow_state_e       w_flow_nxt;
  logic              w_full;
  logic              w_empty;
  fifo_op_t          w_op;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Action qualification. A pop frees a slot in the same cycle, so a push
  // into a full FIFO with a concurrent pop is accepted and is not an overrun.
  always_comb begin
    w_op         = '0;
    w_op.pop     = rd & ~flush & ~w_empty;
    w_op.push    = rx_rcv & ~flush & (~w_full | w_op.pop);
    w_op.ovf_set = rx_rcv & ~flush & w_full & ~w_op.pop;
  end

  // Next occupancy; the flow FSM looks at this so rts_n moves with count.
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_op.push && !w_op.pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_op.pop && !w_op.push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_op.push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_op.pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Sticky overrun; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_op.ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Flow FSM: state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flow <= FLOW_ON;
    end else begin
      r_flow <= w_flow_nxt;
    end
  end

  // Flow FSM: next state with watermark hysteresis.
  always_comb begin
    w_flow_nxt = r_flow;
    case (r_flow)
      FLOW_ON: begin
        if (w_count_nxt >= CW'(HI_WM)) begin
          w_flow_nxt = FLOW_OFF;
        end
      end
      FLOW_OFF: begin
        if (w_count_nxt <= CW'(LO_WM)) begin
          w_flow_nxt = FLOW_ON;
        end
      end
      default: w_flow_nxt = FLOW_ON;
    endcase
  end

  // Flow FSM: output decode.
  always_comb begin
    rts_n = 1'b0;
    if (r_flow == FLOW_OFF) begin
      rts_n = 1'b1;
    end
  end

  rxfifo_ram #(
    .AW (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_op.push),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  // Outputs decoded from registers only.
  assign count   = r_count;
  assign ready   = ~w_empty;
  assign ovf     = r_ovf;
  assign rd_data = w_empty ? 8'h00 : w_ram_rdata;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
module tb_uart_rx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_rcv;
  logic [7:0] rx_data;
  logic       rd;
  logic       flush;
  logic       ovf_clr;
  logic [7:0] rd_data;
  logic       ready;
  logic [3:0] count;
  logic       ovf;
  logic       rts_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_ctrl dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_rcv  (rx_rcv),
    .rx_data (rx_data),
    .rd      (rd),
    .flush   (flush),
    .ovf_clr (ovf_clr),
    .rd_data (rd_data),
    .ready   (ready),
    .count   (count),
    .ovf     (ovf),
    .rts_n   (rts_n)
  );

  typedef struct packed {
    logic       rcv;
    logic [7:0] d;
    logic       rd;
    logic       fl;
    logic       oc;
    logic [7:0] e_data;
    logic       e_rdy;
    logic [3:0] e_cnt;
    logic       e_ovf;
    logic       e_rts;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic rcv, input logic [7:0] d, input logic r,
                              input logic fl, input logic oc, input logic [7:0] ed,
                              input logic er, input logic [3:0] ec, input logic eo,
                              input logic ers);
    vec_t v;
    v.rcv = rcv; v.d = d; v.rd = r; v.fl = fl; v.oc = oc;
    v.e_data = ed; v.e_rdy = er; v.e_cnt = ec; v.e_ovf = eo; v.e_rts = ers;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rcv, input logic [7:0] d, input logic r,
                       input logic fl, input logic oc);
    rx_rcv = rcv; rx_data = d; rd = r; flush = fl; ovf_clr = oc;
  endtask

  // Drive on the falling edge, compare 1 time unit after the rising edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    drive(v.rcv, v.d, v.rd, v.fl, v.oc);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rd_data", idx, 32'(rd_data), 32'(e.e_data));
    chk("ready",   idx, 32'(ready),   32'(e.e_rdy));
    chk("count",   idx, 32'(count),   32'(e.e_cnt));
    chk("ovf",     idx, 32'(ovf),     32'(e.e_ovf));
    chk("rts_n",   idx, 32'(rts_n),   32'(e.e_rts));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rd_data"}, 0, 32'(rd_data), 32'h00);
    chk({nm, "_ready"},   0, 32'(ready),   32'h0);
    chk({nm, "_count"},   0, 32'(count),   32'h0);
    chk({nm, "_ovf"},     0, 32'(ovf),     32'h0);
    chk({nm, "_rts_n"},   0, 32'(rts_n),   32'h0);
  endtask

  initial begin
    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_rts;
    logic       pop_ok;
    logic [7:0] exp_d;

    rstn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rstn = 1'b1;

    // Basic push / show-ahead / pop.
    vecs.push_back(mk(1, 8'h41, 0, 0, 0, 8'h41, 1, 4'd1, 0, 0));
    vecs.push_back(mk(1, 8'h42, 0, 0, 0, 8'h41, 1, 4'd2, 0, 0));
    vecs.push_back(mk(1, 8'h43, 0, 0, 0, 8'h41, 1, 4'd3, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h42, 1, 4'd2, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h43, 1, 4'd1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 4'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 4'd0, 0, 0));
    // Fill, high watermark, overrun, drain, low watermark, ovf_clr.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 8'(i), 0, 0, 0, 8'h00, 1, 4'(i + 1), 0, (i + 1) >= 6));
    vecs.push_back(mk(1, 8'h55, 0, 0, 0, 8'h00, 1, 4'd8, 1, 1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, (i == 7) ? 8'h00 : 8'(i + 1), i != 7,
                        4'(7 - i), 1, (7 - i) > 2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 4'd0, 0, 0));
    // Full FIFO with push and pop in the same cycle.
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 4'd0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 8'(i), 0, 0, 0, 8'h00, 1, 4'(i + 1), 0, (i + 1) >= 6));
    vecs.push_back(mk(1, 8'hAA, 1, 0, 0, 8'h01, 1, 4'd8, 0, 1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 8'h00, 1, 0, 0,
                        (i <= 5) ? 8'(i + 2) : ((i == 6) ? 8'hAA : 8'h00),
                        i != 7, 4'(7 - i), 0, (7 - i) > 2));
    // Empty FIFO with push and pop in the same cycle.
    vecs.push_back(mk(1, 8'h5A, 1, 0, 0, 8'h5A, 1, 4'd1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 4'd0, 0, 0));
    // Flush with concurrent push while rts_n=1 and ovf=1.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 8'(8'h10 + i), 0, 0, 0, 8'h10, 1, 4'(i + 1), 0, (i + 1) >= 6));
    vecs.push_back(mk(1, 8'h99, 0, 0, 0, 8'h10, 1, 4'd8, 1, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'(8'h11 + i), 1, 4'(7 - i), 1, 1));
    vecs.push_back(mk(1, 8'h77, 0, 1, 0, 8'h00, 0, 4'd0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 4'd0, 1, 0));
    // Overrun and ovf_clr in the same cycle: set wins.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 8'(8'h20 + i), 0, 0, 0, 8'h20, 1, 4'(i + 1), 1, (i + 1) >= 6));
    vecs.push_back(mk(1, 8'h33, 0, 0, 1, 8'h20, 1, 4'd8, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h20, 1, 4'd8, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 4'd0, 0, 0));
    // Traffic before the asynchronous reset.
    vecs.push_back(mk(1, 8'hE1, 0, 0, 0, 8'hE1, 1, 4'd1, 0, 0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1, 8'(8'hE2 + i), 0, 0, 0, 8'hE1, 1, 4'(i + 2), 0, (i + 2) >= 6));
    vecs.push_back(mk(1, 8'hEE, 0, 0, 0, 8'hE1, 1, 4'd8, 1, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset mid-traffic: outputs clear before any clock edge.
    @(posedge clk);
    #3;
    drive(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    apply(mk(1, 8'hC3, 0, 0, 0, 8'hC3, 1, 4'd1, 0, 0), 1000);

    // Random traffic against a byte-queue scoreboard.
    mq = {8'hC3};
    m_ovf = 1'b0;
    m_rts = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 4),
            1'b0, 1'b0);
      pop_ok = rd && (mq.size() > 0);
      if (pop_ok) void'(mq.pop_front());
      if (rx_rcv) begin
        if (mq.size() < 8) mq.push_back(rx_data);
        else m_ovf = 1'b1;
      end
      if (!m_rts && mq.size() >= 6) m_rts = 1'b1;
      else if (m_rts && mq.size() <= 2) m_rts = 1'b0;
      @(posedge clk);
      #1;
      exp_d = (mq.size() > 0) ? mq[0] : 8'h00;
      chk("rnd_rd_data", n, 32'(rd_data), 32'(exp_d));
      chk("rnd_count",   n, 32'(count),   32'(mq.size()));
      chk("rnd_ready",   n, 32'(ready),   32'(mq.size() > 0));
      chk("rnd_ovf",     n, 32'(ovf),     32'(m_ovf));
      chk("rnd_rts_n",   n, 32'(rts_n),   32'(m_rts));
    end

    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
